// File: rtl/fork_ctrl_lanes.sv
// fork_ctrl_lanes
// Fork/join controller: on an accepted start it launches up to N_LANES
// timed worker lanes, counts each lane down from its own delay, reports a
// per-lane status and resolves the join according to the latched policy
// (join all, join_any with kill of the losers, or join_none/detach).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        launch request, only honoured while busy=0
//   join_mode    0=join, 1=join_any, 2=join_none, 3=join (latched on start)
//   lane_en      lanes to launch (latched on start)
//   delay_i      per-lane delay, lane i at [i*CNT_W +: CNT_W] (latched on start)
//   kill_all     kill every RUNNING lane on the next edge
//   busy         a lane is RUNNING or the join is still pending
//   done         one-cycle pulse when the join condition is met
//   winner       lowest-index finishing lane of a join_any
//   winner_vld   winner is meaningful; held until the next accepted start
//   lane_fire    per-lane one-cycle pulse when that lane finishes
//   lane_status  2 bits per lane: 0=IDLE, 1=RUNNING, 2=FINISHED, 3=KILLED
module fork_ctrl_lanes #(
   parameter int N_LANES = 3,
   parameter int CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [1:0]                 join_mode,
   input  logic [N_LANES-1:0]         lane_en,
   input  logic [N_LANES*CNT_W-1:0]   delay_i,
   input  logic                       kill_all,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 winner,
   output logic                       winner_vld,
   output logic [N_LANES-1:0]         lane_fire,
   output logic [2*N_LANES-1:0]       lane_status
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DETACH = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      M_ALL  = 2'd0,
      M_ANY  = 2'd1,
      M_NONE = 2'd2
   } mode_t;

   localparam logic [1:0] LS_IDLE = 2'd0;
   localparam logic [1:0] LS_RUN  = 2'd1;
   localparam logic [1:0] LS_FIN  = 2'd2;
   localparam logic [1:0] LS_KILL = 2'd3;

   state_t                     state_q, state_d;
   mode_t                      mode_q, mode_d;
   logic [2*N_LANES-1:0]       lane_status_q, lane_status_d;
   logic [N_LANES*CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_LANES-1:0]         lane_fire_q, lane_fire_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;
   logic                       winner_vld_q, winner_vld_d;
   logic [2:0]                 winner_q, winner_d;

   logic [N_LANES-1:0]         fire_s;
   logic [N_LANES-1:0]         running_s;
   logic                       kill_s;

   // Mode 3 is an alias of the plain join.
   function automatic mode_t decode_mode(input logic [1:0] m);
      mode_t r;
      case (m)
         2'd1:    r = M_ANY;
         2'd2:    r = M_NONE;
         default: r = M_ALL;
      endcase
      return r;
   endfunction

   // Lowest set bit wins; scanning from the top lets lower lanes overwrite.
   function automatic logic [2:0] lowest_set(input logic [N_LANES-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = N_LANES-1; i >= 0; i--) begin
         idx = v[i] ? 3'(i) : idx;
      end
      return idx;
   endfunction

   // Next-state: accept, lane countdown, join resolution and kill handling.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      lane_status_d = lane_status_q;
      cnt_d         = cnt_q;
      lane_fire_d   = {N_LANES{1'b0}};
      done_d        = 1'b0;
      winner_d      = winner_q;
      winner_vld_d  = winner_vld_q;
      fire_s        = {N_LANES{1'b0}};
      running_s     = {N_LANES{1'b0}};
      kill_s        = 1'b0;

      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d      = ST_RUN;
            mode_d       = decode_mode(join_mode);
            winner_d     = 3'd0;
            winner_vld_d = 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
               if (lane_en[i]) begin
                  lane_status_d[2*i +: 2]  = LS_RUN;
                  cnt_d[i*CNT_W +: CNT_W]  = delay_i[i*CNT_W +: CNT_W];
               end else begin
                  lane_status_d[2*i +: 2]  = LS_IDLE;
                  cnt_d[i*CNT_W +: CNT_W]  = {CNT_W{1'b0}};
               end
            end
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         for (int i = 0; i < N_LANES; i++) begin
            fire_s[i] = (lane_status_q[2*i +: 2] == LS_RUN) &&
                        (cnt_q[i*CNT_W +: CNT_W] == {CNT_W{1'b0}});
         end

         // A join_any winner kills the remaining lanes on the same edge.
         kill_s = kill_all ||
                  ((state_q == ST_RUN) && (mode_q == M_ANY) && (|fire_s));

         // Finishing beats killing; killed lanes freeze their counter.
         for (int i = 0; i < N_LANES; i++) begin
            if (fire_s[i]) begin
               lane_status_d[2*i +: 2] = LS_FIN;
            end else if (lane_status_q[2*i +: 2] == LS_RUN) begin
               if (kill_s) begin
                  lane_status_d[2*i +: 2] = LS_KILL;
               end else begin
                  cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] - CNT_W'(1);
               end
            end else begin
               lane_status_d[2*i +: 2] = lane_status_q[2*i +: 2];
            end
         end

         for (int i = 0; i < N_LANES; i++) begin
            running_s[i] = (lane_status_d[2*i +: 2] == LS_RUN);
         end

         lane_fire_d = fire_s;

         if ((state_q == ST_RUN) && (mode_q == M_ANY) && (|fire_s)) begin
            winner_d     = lowest_set(fire_s);
            winner_vld_d = 1'b1;
         end else begin
            winner_d     = winner_q;
            winner_vld_d = winner_vld_q;
         end

         case (state_q)
            ST_RUN: begin
               if (mode_q == M_NONE) begin
                  done_d  = 1'b1;
                  state_d = (|running_s) ? ST_DETACH : ST_IDLE;
               end else if (!(|running_s)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DETACH: begin
               state_d = (|running_s) ? ST_DETACH : ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State, lane and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         mode_q        <= M_ALL;
         lane_status_q <= {(2*N_LANES){1'b0}};
         cnt_q         <= {(N_LANES*CNT_W){1'b0}};
         lane_fire_q   <= {N_LANES{1'b0}};
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         winner_q      <= 3'd0;
         winner_vld_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         lane_status_q <= lane_status_d;
         cnt_q         <= cnt_d;
         lane_fire_q   <= lane_fire_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         winner_q      <= winner_d;
         winner_vld_q  <= winner_vld_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign winner      = winner_q;
   assign winner_vld  = winner_vld_q;
   assign lane_fire   = lane_fire_q;
   assign lane_status = lane_status_q;

endmodule

// File: tb/tb_fork_ctrl_lanes.sv
// Self-checking bench for fork_ctrl_lanes (N_LANES=3, CNT_W=8).
// The reference model describes each job by its accept edge, per-lane
// finish edges and the first kill edge, and derives every output from those
// times; directed tests additionally pin hand-computed values.
module tb_fork_ctrl_lanes;
   localparam int N   = 3;
   localparam int W   = 8;
   localparam int BIG = 1000000;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [1:0]      join_mode;
   logic [N-1:0]    lane_en;
   logic [N*W-1:0]  delay_i;
   logic            kill_all;
   logic            busy;
   logic            done;
   logic [2:0]      winner;
   logic            winner_vld;
   logic [N-1:0]    lane_fire;
   logic [2*N-1:0]  lane_status;

   int n_chk  = 0;
   int n_fail = 0;

   // model of the current job, in absolute edge numbers
   int t        = 0;
   bit have_job = 1'b0;
   int a_m      = 0;
   int mode_m   = 0;
   bit en_m   [N];
   int fire_m [N];
   int kill_m   = BIG;

   fork_ctrl_lanes #(.N_LANES(N), .CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .join_mode(join_mode),
      .lane_en(lane_en), .delay_i(delay_i), .kill_all(kill_all),
      .busy(busy), .done(done), .winner(winner), .winner_vld(winner_vld),
      .lane_fire(lane_fire), .lane_status(lane_status)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, t);
      end
   endtask

   // edge at which lane i stops running (finish or kill)
   function automatic int stop_of(input int i);
      int cut;
      int mn;
      cut = kill_m;
      if (mode_m == 1) begin
         mn = BIG;
         for (int k = 0; k < N; k++)
            if (en_m[k] && fire_m[k] < mn) mn = fire_m[k];
         cut = (mn < kill_m) ? mn : kill_m;
      end
      return (fire_m[i] <= cut) ? fire_m[i] : cut;
   endfunction

   function automatic int busy_end();
      int be;
      be = a_m + 1;
      for (int k = 0; k < N; k++)
         if (en_m[k] && stop_of(k) > be) be = stop_of(k);
      return be;
   endfunction

   function automatic int done_edge();
      return (mode_m == 2) ? a_m + 1 : busy_end();
   endfunction

   function automatic bit busy_at(input int c);
      return have_job && (c >= a_m) && (c < busy_end());
   endfunction

   // model: track accepts, kills and reset
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            have_job = 1'b0;
            kill_m   = BIG;
         end else begin
            t++;
            if (busy_at(t - 1)) begin
               if (kill_all && kill_m == BIG) kill_m = t;
            end else if (start) begin
               have_job = 1'b1;
               a_m      = t;
               kill_m   = BIG;
               mode_m   = (join_mode == 2'd1) ? 1 : ((join_mode == 2'd2) ? 2 : 0);
               for (int k = 0; k < N; k++) begin
                  en_m[k]   = lane_en[k];
                  fire_m[k] = t + int'(delay_i[k*W +: W]) + 1;
               end
            end
         end
      end
   end

   // compare every cycle on the falling edge
   initial begin
      logic [2*N-1:0] e_st;
      logic [N-1:0]   e_fire;
      logic           e_done, e_busy, e_wv, found;
      logic [2:0]     e_win;
      int             dt, st;
      forever begin
         @(negedge clk);
         e_st = '0; e_fire = '0; e_done = 1'b0; e_busy = 1'b0;
         e_wv = 1'b0; e_win = 3'd0; found = 1'b0;
         if (have_job) begin
            dt = done_edge();
            for (int k = 0; k < N; k++) begin
               if (en_m[k]) begin
                  st = stop_of(k);
                  if (t < st)                e_st[2*k +: 2] = 2'd1;
                  else if (st == fire_m[k])  e_st[2*k +: 2] = 2'd2;
                  else                       e_st[2*k +: 2] = 2'd3;
                  if (st == fire_m[k] && t == fire_m[k]) e_fire[k] = 1'b1;
               end
            end
            e_done = (t == dt);
            e_busy = (t < busy_end());
            if (mode_m == 1) begin
               for (int k = 0; k < N; k++) begin
                  if (!found && en_m[k] && stop_of(k) == fire_m[k] && fire_m[k] == dt) begin
                     found = 1'b1;
                     e_win = 3'(k);
                  end
               end
               if (!(found && t >= dt)) e_win = 3'd0;
               e_wv = found && (t >= dt);
            end
         end
         check("m_status", 32'(lane_status), 32'(e_st));
         check("m_fire",   32'(lane_fire),   32'(e_fire));
         check("m_done",   32'(done),        32'(e_done));
         check("m_busy",   32'(busy),        32'(e_busy));
         check("m_winner", 32'(winner),      32'(e_win));
         check("m_wvld",   32'(winner_vld),  32'(e_wv));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // returns at the falling edge right after the accept edge (cycle 0)
   task automatic launch(input logic [1:0] m, input logic [N-1:0] en, input logic [N*W-1:0] d);
      @(negedge clk);
      start = 1'b1; join_mode = m; lane_en = en; delay_i = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; join_mode = 2'd0; lane_en = '0;
      delay_i = '0; kill_all = 1'b0;
      step(3);
      check("rst_busy",   32'(busy),        32'd0);
      check("rst_status", 32'(lane_status), 32'd0);
      check("rst_wvld",   32'(winner_vld),  32'd0);
      check("rst_winner", 32'(winner),      32'd0);
      rst_n = 1'b1;
      step(2);

      // join_any {10,10,30}
      launch(2'd1, 3'b111, {8'd30, 8'd10, 8'd10});
      step(1);
      check("any_busy1", 32'(busy), 32'd1);
      step(9);
      check("any_fire10", 32'(lane_fire), 32'd0);
      step(1);
      check("any_fire",   32'(lane_fire),   32'b011);
      check("any_done",   32'(done),        32'd1);
      check("any_winner", 32'(winner),      32'd0);
      check("any_wvld",   32'(winner_vld),  32'd1);
      check("any_status", 32'(lane_status), 32'b11_10_10);
      check("any_busy",   32'(busy),        32'd0);
      step(25);
      check("any_hold",   32'(lane_status), 32'b11_10_10);

      // join {10,10,30}
      launch(2'd0, 3'b111, {8'd30, 8'd10, 8'd10});
      step(11);
      check("all_fire11", 32'(lane_fire), 32'b011);
      check("all_done11", 32'(done),      32'd0);
      step(20);
      check("all_fire31", 32'(lane_fire),   32'b100);
      check("all_done31", 32'(done),        32'd1);
      check("all_wvld",   32'(winner_vld),  32'd0);
      check("all_status", 32'(lane_status), 32'b10_10_10);
      step(1);

      // join_none {5,0,20}, ignored start at cycle 10
      launch(2'd2, 3'b111, {8'd20, 8'd0, 8'd5});
      step(1);
      check("none_done1", 32'(done),      32'd1);
      check("none_fire1", 32'(lane_fire), 32'b010);
      check("none_busy1", 32'(busy),      32'd1);
      step(5);
      check("none_fire6", 32'(lane_fire), 32'b001);
      step(3);
      start = 1'b1; join_mode = 2'd0; lane_en = 3'b001; delay_i = '0;
      step(1);
      start = 1'b0;
      step(1);
      check("none_ignore", 32'(lane_status), 32'b01_10_10);
      step(10);
      check("none_fire21", 32'(lane_fire), 32'b100);
      check("none_busy21", 32'(busy),      32'd0);
      check("none_done21", 32'(done),      32'd0);
      step(1);

      // kill_all at cycle 8, join {3,50,50}
      launch(2'd0, 3'b111, {8'd50, 8'd50, 8'd3});
      step(4);
      check("kill_fire4", 32'(lane_fire), 32'b001);
      step(4);
      kill_all = 1'b1;
      step(1);
      kill_all = 1'b0;
      check("kill_status", 32'(lane_status), 32'b11_11_10);
      check("kill_done",   32'(done),        32'd1);
      check("kill_wvld",   32'(winner_vld),  32'd0);
      step(1);

      // kill_all on the edge lane 0 finishes
      launch(2'd0, 3'b111, {8'd50, 8'd50, 8'd3});
      step(3);
      kill_all = 1'b1;
      step(1);
      kill_all = 1'b0;
      check("killc_status", 32'(lane_status), 32'b11_11_10);
      check("killc_fire",   32'(lane_fire),   32'b001);
      check("killc_done",   32'(done),        32'd1);
      step(1);

      // no lanes enabled
      launch(2'd0, 3'b000, {8'd1, 8'd1, 8'd1});
      check("none_en_busy0", 32'(busy), 32'd1);
      step(1);
      check("none_en_done",   32'(done),        32'd1);
      check("none_en_status", 32'(lane_status), 32'd0);
      check("none_en_busy",   32'(busy),        32'd0);
      step(1);

      // maximum delay
      launch(2'd0, 3'b010, {8'd0, 8'd255, 8'd0});
      step(255);
      check("max_fire255", 32'(lane_fire), 32'd0);
      step(1);
      check("max_fire256", 32'(lane_fire), 32'b010);
      check("max_done256", 32'(done),      32'd1);
      step(1);

      // join_mode 3 acts as join
      launch(2'd3, 3'b101, {8'd2, 8'd9, 8'd4});
      step(3);
      check("m3_fire3", 32'(lane_fire), 32'b100);
      check("m3_done3", 32'(done),      32'd0);
      step(2);
      check("m3_fire5",   32'(lane_fire),   32'b001);
      check("m3_done5",   32'(done),        32'd1);
      check("m3_status",  32'(lane_status), 32'b10_00_10);
      step(1);

      // join_any with a non-zero lowest winner
      launch(2'd1, 3'b110, {8'd4, 8'd4, 8'd7});
      step(5);
      check("any1_fire",   32'(lane_fire),   32'b110);
      check("any1_winner", 32'(winner),      32'd1);
      check("any1_wvld",   32'(winner_vld),  32'd1);
      check("any1_status", 32'(lane_status), 32'b10_10_00);
      step(1);

      // reset mid join_any, then fresh start
      launch(2'd1, 3'b111, {8'd40, 8'd40, 8'd40});
      step(5);
      #2 rst_n = 1'b0;
      #1;
      check("rmid_busy",   32'(busy),        32'd0);
      check("rmid_status", 32'(lane_status), 32'd0);
      check("rmid_wvld",   32'(winner_vld),  32'd0);
      check("rmid_done",   32'(done),        32'd0);
      step(2);
      rst_n = 1'b1;
      launch(2'd1, 3'b111, {8'd3, 8'd2, 8'd1});
      step(2);
      check("rnew_winner", 32'(winner),     32'd0);
      check("rnew_wvld",   32'(winner_vld), 32'd1);
      check("rnew_fire",   32'(lane_fire),  32'b001);
      check("rnew_done",   32'(done),       32'd1);
      wait_idle(300);
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
